// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// State encoding, requester id and the zero-register address.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/wb_port_arbiter_flopre.sv
// Resettable flop with load enable (flopr plus enable).
// Clears asynchronously; loads d only when en is high.
module flopre #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // hold the value unless enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// Bursts lock the port up to MAX_BURST beats; XZR writes are dropped.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N         = 64,
  parameter int AW        = 5,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [N-1:0]  req0_data,
  input  logic          req0_last,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [N-1:0]  req1_data,
  input  logic          req1_last,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [N-1:0]  rf_wd,
  output logic          grant_id,
  output logic          busy
);

  localparam int CW = 5;

  state_t          state, state_n;
  req_id_t         prio, prio_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic            xfer0, xfer1, xfer;
  req_id_t         win;
  logic [AW-1:0]   win_addr;
  logic [N-1:0]    win_data;
  logic            win_last;
  logic            term;

  // grant: owner keeps the port; idle picks by validity then prio
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            req0_ready = ~prio;
            req1_ready = prio;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
        OWN0:    req0_ready = 1'b1;
        OWN1:    req1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign xfer  = xfer0 | xfer1;
  assign win   = xfer1;

  assign win_addr = win ? req1_addr : req0_addr;
  assign win_data = win ? req1_data : req0_data;
  assign win_last = win ? req1_last : req0_last;

  assign term = win_last | (cnt == CW'(MAX_BURST - 1));
  assign busy = (state != IDLE);

  // next state, beat count and priority on each accepted beat
  always_comb begin
    state_n = state;
    prio_n  = prio;
    cnt_n   = cnt;
    if (xfer) begin
      if (term) begin
        state_n = IDLE;
        cnt_n   = '0;
        prio_n  = ~win;
      end else begin
        state_n = win ? OWN1 : OWN0;
        cnt_n   = cnt + 1'b1;
      end
    end
  end

  // arbitration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      prio  <= prio_n;
      cnt   <= cnt_n;
    end
  end

  // write strobe and owner of the registered beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      rf_we <= xfer & (win_addr != AW'(XZR));
      if (xfer) grant_id <= win;
    end
  end

  flopre #(.N(AW)) u_wa (
    .clk   (clk),
    .reset (reset),
    .en    (xfer),
    .d     (win_addr),
    .q     (rf_wa)
  );

  flopre #(.N(N)) u_wd (
    .clk   (clk),
    .reset (reset),
    .en    (xfer),
    .d     (win_data),
    .q     (rf_wd)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
// Inputs change 1ns after rising edges; outputs sampled there too.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_last, req0_ready;
  logic [4:0]  req0_addr;
  logic [63:0] req0_data;
  logic        req1_valid, req1_last, req1_ready;
  logic [4:0]  req1_addr;
  logic [63:0] req1_data;
  logic        rf_we, grant_id, busy;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.N(64), .AW(5), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [4:0] a,
                      input logic [63:0] d, input logic l);
    req0_valid = v; req0_addr = a; req0_data = d; req0_last = l;
  endtask

  task automatic drv1(input logic v, input logic [4:0] a,
                      input logic [63:0] d, input logic l);
    req1_valid = v; req1_addr = a; req1_data = d; req1_last = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  logic [63:0] d0 [3];
  logic [63:0] d1 [3];
  logic [63:0] exp_wd [6];
  int i0, i1;
  logic a0, a1;

  initial begin
    reset = 1'b1;
    drv0(1'b1, 5'd7, 64'h55, 1'b1);
    drv1(1'b1, 5'd8, 64'h66, 1'b1);

    // 1: reset held with both valid
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_r0", 64'(req0_ready), 64'd0);
      chk("rst_r1", 64'(req1_ready), 64'd0);
      chk("rst_we", 64'(rf_we), 64'd0);
      chk("rst_wa", 64'(rf_wa), 64'd0);
      chk("rst_wd", rf_wd, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_gid", 64'(grant_id), 64'd0);
      step();
    end
    drv0(1'b0, 5'd0, 64'd0, 1'b0);
    drv1(1'b0, 5'd0, 64'd0, 1'b0);
    reset = 1'b0;
    #1;

    // 2: single beat from req0
    drv0(1'b1, 5'd3, 64'hA, 1'b1);
    #1;
    chk("t2_r0", 64'(req0_ready), 64'd1);
    step();
    drv0(1'b0, 5'd0, 64'd0, 1'b0);
    chk("t2_we", 64'(rf_we), 64'd1);
    chk("t2_wa", 64'(rf_wa), 64'd3);
    chk("t2_wd", rf_wd, 64'hA);
    chk("t2_gid", 64'(grant_id), 64'd0);
    chk("t2_busy", 64'(busy), 64'd0);
    step();
    chk("t2_we_off", 64'(rf_we), 64'd0);
    chk("t2_wd_hold", rf_wd, 64'hA);

    // 3: alternating single beats after reset
    do_reset();
    d0[0] = 64'h1;  d0[1] = 64'h2;  d0[2] = 64'h3;
    d1[0] = 64'h11; d1[1] = 64'h12; d1[2] = 64'h13;
    exp_wd[0] = 64'h1; exp_wd[1] = 64'h11; exp_wd[2] = 64'h2;
    exp_wd[3] = 64'h12; exp_wd[4] = 64'h3; exp_wd[5] = 64'h13;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      drv0(i0 < 3, 5'd1, (i0 < 3) ? d0[i0] : 64'd0, 1'b1);
      drv1(i1 < 3, 5'd2, (i1 < 3) ? d1[i1] : 64'd0, 1'b1);
      #1;
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      step();
      chk("t3_wd", rf_wd, exp_wd[k]);
      chk("t3_gid", 64'(grant_id), 64'(k % 2));
      if (a0) i0++;
      if (a1) i1++;
    end
    drv0(1'b0, 5'd0, 64'd0, 1'b0);
    drv1(1'b0, 5'd0, 64'd0, 1'b0);

    // 4a: req0 single beat so prio points at req1
    drv0(1'b1, 5'd4, 64'h40, 1'b1);
    step();
    // req1 3-beat burst while req0 keeps asking
    drv0(1'b1, 5'd5, 64'h50, 1'b1);
    for (int b = 0; b < 3; b++) begin
      drv1(1'b1, 5'd9, 64'h90 + 64'(b), b == 2);
      #1;
      chk("t4_r0_lock", 64'(req0_ready), 64'd0);
      chk("t4_r1", 64'(req1_ready), 64'd1);
      chk("t4_busy", 64'(busy), 64'(b != 0));
      step();
      chk("t4_wd", rf_wd, 64'h90 + 64'(b));
      chk("t4_gid", 64'(grant_id), 64'd1);
    end
    drv1(1'b0, 5'd0, 64'd0, 1'b0);
    chk("t4_busy_end", 64'(busy), 64'd0);
    #1;
    chk("t4_r0_won", 64'(req0_ready), 64'd1);
    step();
    chk("t4_wd_r0", rf_wd, 64'h50);
    chk("t4_gid_r0", 64'(grant_id), 64'd0);

    // 4b: req0 burst, last never set, forced release at 4
    drv0(1'b1, 5'd6, 64'h60, 1'b0);
    #1;
    chk("t4b_r0_first", 64'(req0_ready), 64'd1);
    step();
    drv1(1'b1, 5'd10, 64'hA0, 1'b1);
    drv0(1'b1, 5'd6, 64'h61, 1'b0);
    step();
    chk("t4b_wd1", rf_wd, 64'h61);
    // gap: owner idle, lock holds
    drv0(1'b0, 5'd6, 64'h62, 1'b0);
    #1;
    chk("t4b_gap_r1", 64'(req1_ready), 64'd0);
    chk("t4b_gap_busy", 64'(busy), 64'd1);
    step();
    chk("t4b_gap_we", 64'(rf_we), 64'd0);
    for (int b = 2; b < 4; b++) begin
      drv0(1'b1, 5'd6, 64'h60 + 64'(b), 1'b0);
      #1;
      chk("t4b_r0", 64'(req0_ready), 64'd1);
      chk("t4b_r1", 64'(req1_ready), 64'd0);
      step();
      chk("t4b_wd", rf_wd, 64'h60 + 64'(b));
    end
    chk("t4b_release", 64'(busy), 64'd0);
    drv0(1'b1, 5'd6, 64'h64, 1'b0);
    #1;
    chk("t4b_r1_won", 64'(req1_ready), 64'd1);
    chk("t4b_r0_lost", 64'(req0_ready), 64'd0);
    step();
    chk("t4b_wd_r1", rf_wd, 64'hA0);
    chk("t4b_gid_r1", 64'(grant_id), 64'd1);
    drv0(1'b0, 5'd0, 64'd0, 1'b0);
    drv1(1'b0, 5'd0, 64'd0, 1'b0);

    // 5: write to XZR is suppressed
    drv0(1'b1, 5'd31, 64'hFF, 1'b1);
    #1;
    chk("t5_r0", 64'(req0_ready), 64'd1);
    step();
    drv0(1'b0, 5'd0, 64'd0, 1'b0);
    chk("t5_we", 64'(rf_we), 64'd0);
    chk("t5_wa", 64'(rf_wa), 64'd31);
    chk("t5_wd", rf_wd, 64'hFF);

    // 6: reset mid-burst
    drv1(1'b1, 5'd12, 64'hC0, 1'b0);
    step();
    chk("t6_we_b1", 64'(rf_we), 64'd1);
    chk("t6_busy_b1", 64'(busy), 64'd1);
    drv1(1'b1, 5'd12, 64'hC1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_we_async", 64'(rf_we), 64'd0);
    chk("t6_busy_async", 64'(busy), 64'd0);
    chk("t6_r1_rst", 64'(req1_ready), 64'd0);
    step();
    reset = 1'b0;
    drv0(1'b1, 5'd13, 64'hD0, 1'b1);
    drv1(1'b1, 5'd14, 64'hE0, 1'b1);
    #1;
    chk("t6_r0_prio", 64'(req0_ready), 64'd1);
    chk("t6_r1_prio", 64'(req1_ready), 64'd0);
    step();
    chk("t6_wd", rf_wd, 64'hD0);
    chk("t6_gid", 64'(grant_id), 64'd0);
    drv0(1'b0, 5'd0, 64'd0, 1'b0);
    drv1(1'b0, 5'd0, 64'd0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
